imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width of the instruction memory write port.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 byte_valid  input  1  upstream byte present.
REQ-005 byte_data  input  8  upstream byte.
REQ-006 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid && byte_ready.
REQ-007 mem_wren  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-008 mem_addr  output  ADDR_W  word address for write.
REQ-009 mem_wdata  output  32  assembled instruction word.
REQ-010 cpu_hold  output  1  holds CPU in reset while a load is in progress.
REQ-011 load_done  output  1  one-cycle pulse at load completion.
REQ-012 load_err  output  1  sticky checksum-failure flag (LOADER_CHECKSUM_EN only; else tied 0).

Function
REQ-013 FSM states SHALL be IDLE, HDR_LO, HDR_HI, DATA, WRITE, CSUM, DONE.
REQ-014 byte_ready SHALL be 1 in IDLE, HDR_LO, HDR_HI, DATA, CSUM and 0 in WRITE, DONE.
REQ-015 IDLE: accepted byte 0xA5 -> HDR_LO and clear load_err; any other accepted byte discarded, stay IDLE.
REQ-016 HDR_LO/HDR_HI: accepted bytes form word_count[15:0], low byte first; count==0 -> DONE (or CSUM when enabled), else DATA with word index 0.
REQ-017 DATA: four accepted bytes assembled little-endian (first byte -> bits 7:0); after the fourth -> WRITE.
REQ-018 WRITE: mem_wren=1 for exactly one cycle, mem_addr=word index[ADDR_W-1:0], mem_wdata=assembled word; index increments.
REQ-019 Write latency: mem_wren SHALL assert the cycle after the fourth byte's transfer edge.
REQ-020 After WRITE: index==word_count -> DONE (or CSUM), else DATA.
REQ-021 Address SHALL wrap modulo 2^ADDR_W when word_count exceeds memory depth; later words overwrite earlier.
REQ-022 DONE: load_done=1 one cycle, then IDLE.
REQ-023 cpu_hold SHALL be 1 in every state except IDLE, deasserting on the cycle after DONE.
REQ-024 byte_valid without ready (WRITE, DONE) SHALL not be consumed; the byte stays pending upstream.
REQ-025 mem_wren SHALL be 0 outside WRITE; mem_addr/mem_wdata hold last value.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, mem_wren=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, byte_ready=1.
REQ-027 Reset mid-load SHALL discard the partial word and perform no further write.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after the last word, CSUM accepts one byte; XOR of all data bytes mismatching sets load_err; DONE entered either way.
REQ-029 LOADER_CHECKSUM_EN undefined: CSUM unreachable, no checksum byte consumed, load_err constant 0.

Verification
REQ-030 Stream A5 02 00 | 01 00 A0 E3 | 02 10 A0 E3 -> writes 0xE3A00001 @0, 0xE3A01002 @1, load_done one cycle after second write, cpu_hold high from A5 to DONE.
REQ-031 Bytes 00 FF then A5 00 00 -> junk ignored, no write, load_done pulse, cpu_hold high for exactly HDR_LO..DONE.
REQ-032 byte_valid held high continuously through 2-word load -> byte_ready low during WRITE/DONE, no byte lost or duplicated.
REQ-033 rst_n pulsed low after 2 of 4 data bytes, then fresh 1-word load 0x12345678 -> single write @0 of 0x12345678, no earlier write.
REQ-034 ADDR_W=2, count 5 -> addresses 0,1,2,3,0; fifth word overwrites @0.
REQ-035 LOADER_CHECKSUM_EN, 1 word 11 22 33 44 + checksum 44 -> load_err=0; checksum 00 -> load_err=1 until next A5.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed byte stream (0xA5 sync, 16-bit little-endian
// word count, little-endian 32-bit words) and writes each word into instruction memory while
// holding the CPU in reset.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and
// raise a sticky load_err on mismatch.
module imem_loader #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StData,
        StWrite,
        StCsum,
        StDone
    } state_e;

    localparam logic [7:0] SyncByte = 8'hA5;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e StEnd = StCsum;
`else
    localparam state_e StEnd = StDone;
`endif

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [15:0]         idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;    // first three bytes of the word being assembled
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                xfer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                err_q, err_d;
`endif

    assign xfer = byte_valid && byte_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running checksum and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
`endif

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        byte_ready = 1'b1;
        mem_wren   = 1'b0;
        load_done  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (xfer && byte_data == SyncByte) begin
                    state_d = StHdrLo;
`ifdef LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                end
            end
            StHdrLo: begin
                if (xfer) begin
                    count_d[7:0] = byte_data;
                    state_d      = StHdrHi;
                end
            end
            StHdrHi: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    idx_d         = '0;
                    bcnt_d        = '0;
                    state_d       = ({byte_data, count_q[7:0]} == 16'd0) ? StEnd : StData;
                end
            end
            StData: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Latch word and address now so they are stable throughout WRITE
                        wdata_d = {byte_data, asm_q};
                        addr_d  = ADDR_W'(idx_q);
                        state_d = StWrite;
                    end else begin
                        asm_d[{bcnt_q, 3'b000} +: 8] = byte_data;
                    end
                end
            end
            StWrite: begin
                byte_ready = 1'b0;
                mem_wren   = 1'b1;
                idx_d      = idx_q + 16'd1;
                state_d    = (idx_d == count_q) ? StEnd : StData;
            end
            StCsum: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (byte_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                byte_ready = 1'b0;
                load_done  = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q != StIdle);

`ifdef LOADER_CHECKSUM_EN
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (default ADDR_W and ADDR_W=2) share one
// byte source selected by sel; expected writes/done pulses are queued by the stimulus and
// checked by a negedge monitor. Checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid;
    logic       sel;
    logic [7:0] data;
    logic       rdy;

    logic        v0, r0, wren0, hold0, done0, err0;
    logic [10:0] addr0;
    logic [31:0] wd0;
    logic        v1, r1, wren1, hold1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] wd1;

    assign v0  = valid & ~sel;
    assign v1  = valid & sel;
    assign rdy = sel ? r1 : r0;

    imem_loader u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (v0),
        .byte_data  (data),
        .byte_ready (r0),
        .mem_wren   (wren0),
        .mem_addr   (addr0),
        .mem_wdata  (wd0),
        .cpu_hold   (hold0),
        .load_done  (done0),
        .load_err   (err0)
    );

    imem_loader #(.ADDR_W(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (v1),
        .byte_data  (data),
        .byte_ready (r1),
        .mem_wren   (wren1),
        .mem_addr   (addr1),
        .mem_wdata  (wd1),
        .cpu_hold   (hold1),
        .load_done  (done1),
        .load_err   (err1)
    );

`ifdef LOADER_CHECKSUM_EN
    localparam int DoneGap = 2;
`else
    localparam int DoneGap = 1;
`endif

    typedef struct {
        bit          done;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          gap;   // required cycles since previous event, 0 = don't care
    } evt_t;

    evt_t q0[$];
    evt_t q1[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   last_cyc[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic wren, input logic [31:0] addr,
                       input logic [31:0] wd, input logic done, input logic rdy_i,
                       input logic hold, input logic err);
        evt_t e;
        int   qs;
        if (!(wren || done)) return;
        qs = (id == 0) ? q0.size() : q1.size();
        cmp($sformatf("dut%0d ready low in write/done", id), {31'd0, rdy_i}, 32'd0);
        cmp($sformatf("dut%0d hold in write/done", id), {31'd0, hold}, 32'd1);
        if (qs == 0) begin
            cmp($sformatf("dut%0d unexpected event {wren,done}", id), {30'd0, wren, done}, 32'd0);
            return;
        end
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        if (e.done) begin
            cmp($sformatf("dut%0d done {wren,done}", id), {30'd0, wren, done}, 32'd1);
            cmp($sformatf("dut%0d load_err at done", id), {31'd0, err}, {31'd0, e.err});
            if (e.gap != 0)
                cmp($sformatf("dut%0d done latency", id), cyc - last_cyc[id], e.gap);
        end else begin
            cmp($sformatf("dut%0d write {wren,done}", id), {30'd0, wren, done}, 32'd2);
            cmp($sformatf("dut%0d write addr", id), addr, e.addr);
            cmp($sformatf("dut%0d write data", id), wd, e.data);
        end
        last_cyc[id] = cyc;
    endtask

    // Monitor: compare every write/done event against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, wren0, {21'd0, addr0}, wd0, done0, r0, hold0, err0);
            mon(1, wren1, {30'd0, addr1}, wd1, done1, r1, hold1, err1);
        end
    end

    task automatic exp_wr(input int id, input int a, input logic [31:0] d);
        evt_t e;
        e.done = 1'b0; e.addr = a; e.data = d; e.err = 1'b0; e.gap = 0;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic exp_done(input int id, input logic er, input int gap);
        evt_t e;
        e.done = 1'b1; e.addr = 0; e.data = 0; e.err = er; e.gap = gap;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Offer a byte and leave valid high until the caller drops it
    task automatic send(input logic [7:0] b);
        bit took = 1'b0;
        data  = b;
        valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rdy) begin
                took = 1'b1;
                break;
            end
        end
        if (!took) begin
            cmp("byte accepted within bound", {31'd0, rdy}, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send(b);
`else
        if (b == 8'hxx) valid = 1'b0;   // no checksum byte in this build
`endif
    endtask

    task automatic drain(input int id);
        int qs;
        valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #2;
            qs = (id == 0) ? q0.size() : q1.size();
            if (qs == 0) break;
        end
        qs = (id == 0) ? q0.size() : q1.size();
        cmp($sformatf("dut%0d pending events", id), qs, 0);
        cmp($sformatf("dut%0d hold released", id), {31'd0, (id == 0) ? hold0 : hold1}, 32'd0);
    endtask

    task automatic check_reset_outs();
        cmp("rst wren", {30'd0, wren0, wren1}, 32'd0);
        cmp("rst addr0", {21'd0, addr0}, 32'd0);
        cmp("rst wdata0", wd0, 32'd0);
        cmp("rst wdata1", wd1, 32'd0);
        cmp("rst hold", {30'd0, hold0, hold1}, 32'd0);
        cmp("rst done", {30'd0, done0, done1}, 32'd0);
        cmp("rst err", {30'd0, err0, err1}, 32'd0);
        cmp("rst ready", {30'd0, r0, r1}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_cyc[0] = 0;
        last_cyc[1] = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        sel   = 1'b0;
        data  = 8'h00;
        #12;
        check_reset_outs();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-word load, valid held high throughout
        exp_wr(0, 0, 32'hE3A00001);
        exp_wr(0, 1, 32'hE3A01002);
        exp_done(0, 1'b0, DoneGap);
        send(8'hA5);
        cmp("hold after sync", {31'd0, hold0}, 32'd1);
        send(8'h02); send(8'h00);
        send(8'h01); send(8'h00); send(8'hA0); send(8'hE3);
        send(8'h02); send(8'h10); send(8'hA0); send(8'hE3);
        send_csum(8'h13);
        drain(0);
        cmp("wdata holds after load", wd0, 32'hE3A01002);

        // Junk before sync, then zero-length load
        send(8'h00);
        send(8'hFF);
        valid = 1'b0;
        cmp("hold idle after junk", {31'd0, hold0}, 32'd0);
        exp_done(0, 1'b0, 0);
        send(8'hA5);
        cmp("hold after sync (empty)", {31'd0, hold0}, 32'd1);
        send(8'h00); send(8'h00);
        send_csum(8'h00);
        drain(0);

        // Reset mid-word, then a fresh one-word load
        exp_wr(0, 0, 32'h12345678);
        exp_done(0, 1'b0, DoneGap);
        send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send_csum(8'h08);
        drain(0);

        // ADDR_W=2 instance: five words wrap to address 0
        sel = 1'b1;
        send(8'hA5); send(8'h05); send(8'h00);
        for (int i = 0; i < 5; i++) exp_wr(1, i % 4, 32'hC0DE0000 | i);
        exp_done(1, 1'b0, DoneGap);
        for (int i = 0; i < 5; i++) begin
            send(i[7:0]); send(8'h00); send(8'hDE); send(8'hC0);
        end
        send_csum(8'h1A);
        drain(1);
        cmp("dut1 final addr", {30'd0, addr1}, 32'd0);
        cmp("dut1 final wdata", wd1, 32'hC0DE0004);
        sel = 1'b0;
        cmp("load_err clear", {30'd0, err0, err1}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match, then mismatch, then cleared by next sync
        exp_wr(0, 0, 32'h44332211);
        exp_done(0, 1'b0, DoneGap);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h44);
        drain(0);
        cmp("csum ok err", {31'd0, err0}, 32'd0);

        exp_wr(0, 0, 32'h44332211);
        exp_done(0, 1'b1, DoneGap);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h00);
        drain(0);
        cmp("csum bad err sticky", {31'd0, err0}, 32'd1);

        exp_done(0, 1'b0, 0);
        send(8'hA5);
        cmp("err cleared by sync", {31'd0, err0}, 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        drain(0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
